// File: rtl/fre_pkg.sv
// rtl/fre_pkg.sv - shared constants, select codes and FSM encoding for the frequency meter
package fre_pkg;

    localparam longint F_5M   = 64'd5_000_000;
    localparam longint F_1M   = 64'd1_000_000;
    localparam longint F_500K = 64'd500_000;
    localparam longint F_100K = 64'd100_000;
    localparam longint F_50K  = 64'd50_000;

    localparam logic [2:0] SEL_5M   = 3'b000;
    localparam logic [2:0] SEL_1M   = 3'b001;
    localparam logic [2:0] SEL_500K = 3'b010;
    localparam logic [2:0] SEL_100K = 3'b011;
    localparam logic [2:0] SEL_50K  = 3'b100;
    localparam logic [2:0] SEL_NONE = 3'b111;

    localparam int N_CODES = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GATE = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic longint code_freq(input int code);
        case (code)
            0:       return F_5M;
            1:       return F_1M;
            2:       return F_500K;
            3:       return F_100K;
            default: return F_50K;
        endcase
    endfunction

    function automatic longint nom_count(input longint f, input longint gate, input longint clk_hz);
        return f * gate / clk_hz;
    endfunction

endpackage

// File: rtl/fre_meas_sync_edge.sv
// rtl/fre_meas_sync_edge.sv - 2-FF synchronizer plus registered rising-edge detector
module fre_meas_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic d_async,
    output logic rise
);

    logic meta;
    logic sync;
    logic prev;

    // rise appears three clocks after the pin edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            sync <= 1'b0;
            prev <= 1'b0;
            rise <= 1'b0;
        end else begin
            meta <= d_async;
            sync <= meta;
            prev <= sync;
            rise <= sync & ~prev;
        end
    end

endmodule

// File: rtl/fre_meas.sv
// rtl/fre_meas.sv - gated rising-edge frequency meter; FRE_MEAS_CLASSIFY_EN adds select-code classifier
module fre_meas
    import fre_pkg::*;
#(
    parameter longint CLK_HZ      = 50_000_000,
    parameter int     GATE_CYCLES = 50_000,
    parameter int     CNT_W       = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sig_in,
    output logic [CNT_W-1:0] cnt_out,
    output logic             ovf,
    output logic             valid,
    output logic [2:0]       sel_out,
    output logic             sel_hit
);

    localparam int               GC_W      = $clog2(GATE_CYCLES);
    localparam logic [GC_W-1:0]  GATE_LAST = GC_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    state_t           state;
    state_t           state_next;
    logic             rise;
    logic [GC_W-1:0]  gate_cnt;
    logic [CNT_W-1:0] edge_cnt;
    logic             ovf_r;
    logic [2:0]       sel_next;
    logic             hit_next;

    fre_meas_sync_edge u_sync (
        .clk     (clk),
        .rst     (rst),
        .d_async (sig_in),
        .rise    (rise)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (en) state_next = GATE;
            GATE: begin
                if (!en)                         state_next = IDLE;
                else if (gate_cnt == GATE_LAST)  state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // An edge arriving while already saturated is a lost edge and flags overflow
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gate_cnt <= '0;
            edge_cnt <= '0;
            ovf_r    <= 1'b0;
        end else if (state == IDLE && en) begin
            gate_cnt <= '0;
            edge_cnt <= '0;
            ovf_r    <= 1'b0;
        end else if (state == GATE && en) begin
            gate_cnt <= gate_cnt + 1'b1;
            if (rise) begin
                if (edge_cnt == CNT_MAX) ovf_r    <= 1'b1;
                else                     edge_cnt <= edge_cnt + 1'b1;
            end
        end
    end

`ifdef FRE_MEAS_CLASSIFY_EN
    logic [N_CODES-1:0] match;

    for (genvar i = 0; i < N_CODES; i++) begin : g_cmp
        localparam longint NOM  = nom_count(code_freq(i), longint'(GATE_CYCLES), CLK_HZ);
        localparam longint TOL  = NOM >>> 5;
        // A nominal count wider than the counter can never be reached without saturating
        localparam bit     FITS = (NOM < (64'sd1 <<< CNT_W));
        logic signed [CNT_W:0] diff;
        logic        [CNT_W:0] mag;
        assign diff     = $signed({1'b0, edge_cnt}) - $signed({1'b0, NOM[CNT_W-1:0]});
        assign mag      = diff[CNT_W] ? -diff : diff;
        assign match[i] = FITS && (longint'(mag) <= TOL);
    end

    always_comb begin
        sel_next = SEL_NONE;
        hit_next = 1'b0;
        for (int i = N_CODES - 1; i >= 0; i--) begin
            if (match[i] && !ovf_r) begin
                sel_next = 3'(i);
                hit_next = 1'b1;
            end
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = (CLK_HZ > 0);
    assign sel_next   = SEL_NONE;
    assign hit_next   = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_out <= '0;
            ovf     <= 1'b0;
            valid   <= 1'b0;
            sel_out <= SEL_NONE;
            sel_hit <= 1'b0;
        end else begin
            valid <= (state == DONE);
            if (state == DONE) begin
                cnt_out <= edge_cnt;
                ovf     <= ovf_r;
                sel_out <= sel_next;
                sel_hit <= hit_next;
            end
        end
    end

endmodule

// File: tb/tb_fre_meas.sv
// tb/tb_fre_meas.sv - scoreboard bench for fre_meas with a shortened gate
`timescale 1ns/1ps
module tb_fre_meas;

    localparam int GATE  = 5000;
    localparam int CNT_W = 24;
`ifdef FRE_MEAS_CLASSIFY_EN
    localparam bit CLASSIFY = 1'b1;
`else
    localparam bit CLASSIFY = 1'b0;
`endif

    typedef struct packed {
        logic [CNT_W-1:0] cnt;
        logic             ovf;
        logic [2:0]       sel;
        logic             hit;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             sig_in;
    logic [CNT_W-1:0] cnt_out;
    logic             ovf;
    logic             valid;
    logic [2:0]       sel_out;
    logic             sel_hit;
    logic [7:0]       cnt8;
    logic             ovf8;
    logic             valid8;
    logic [2:0]       sel8;
    logic             hit8;

    exp_t exp_q[$];
    int   vcyc[$];
    int   checks     = 0;
    int   errors     = 0;
    int   valid_seen = 0;
    int   cyc        = 0;
    int   period     = 0;
    int   ph         = 0;
    logic prev_valid = 1'b0;

    fre_meas #(.GATE_CYCLES(GATE), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .en(en), .sig_in(sig_in),
        .cnt_out(cnt_out), .ovf(ovf), .valid(valid), .sel_out(sel_out), .sel_hit(sel_hit)
    );

    fre_meas #(.GATE_CYCLES(GATE), .CNT_W(8)) dut8 (
        .clk(clk), .rst(rst), .en(en), .sig_in(sig_in),
        .cnt_out(cnt8), .ovf(ovf8), .valid(valid8), .sel_out(sel8), .sel_hit(hit8)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push(input int cnt, input logic o, input logic [2:0] sel, input logic hit);
        exp_t e;
        e.cnt = CNT_W'(cnt);
        e.ovf = o;
        e.sel = CLASSIFY ? sel : 3'b111;
        e.hit = CLASSIFY ? hit : 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic wait_valid(input string tag, input int n);
        int k = 0;
        while (valid_seen < n && k < GATE + 100) begin
            @(posedge clk); #2;
            k++;
        end
        chk({"timeout_", tag}, 32'(valid_seen >= n), 32'd1);
    endtask

    // Square wave with a whole number of clocks per period so every gate sees an exact count
    initial begin
        sig_in = 1'b0;
        forever begin
            @(negedge clk);
            if (period == 0) begin
                ph     = 0;
                sig_in = 1'b0;
            end else begin
                ph     = (ph + 1 >= period) ? 0 : ph + 1;
                sig_in = (ph < period / 2);
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(posedge clk); #1;
            if (valid) begin
                valid_seen++;
                vcyc.push_back(cyc);
                chk("valid_back_to_back", 32'(prev_valid), 32'd0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("cnt_out", 32'(cnt_out), 32'(e.cnt));
                    chk("ovf", 32'(ovf), 32'(e.ovf));
                    chk("sel_out", 32'(sel_out), 32'(e.sel));
                    chk("sel_hit", 32'(sel_hit), 32'(e.hit));
                end
            end
            prev_valid = valid;
        end
    end

    initial begin
        #(90_000 * 20);
        $display("FAIL watchdog cycles=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_cnt_out", 32'(cnt_out), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_sel_out", 32'(sel_out), 32'd7);
        chk("rst_sel_hit", 32'(sel_hit), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // 5 MHz, two back-to-back gates
        period = 10;
        repeat (10) @(posedge clk);
        push(500, 1'b0, 3'b000, 1'b1);
        push(500, 1'b0, 3'b000, 1'b1);
        @(negedge clk);
        en = 1'b1;
        wait_valid("5m_a", 1);
        chk("w8_cnt_out", 32'(cnt8), 32'd255);
        chk("w8_ovf", 32'(ovf8), 32'd1);
        chk("w8_sel_out", 32'(sel8), 32'd7);
        chk("w8_sel_hit", 32'(hit8), 32'd0);
        wait_valid("5m_b", 2);
        en = 1'b0;
        if (vcyc.size() >= 2) chk("valid_period", 32'(vcyc[1] - vcyc[0]), 32'(GATE + 2));

        // 50 kHz
        period = 1000;
        repeat (10) @(posedge clk);
        push(5, 1'b0, 3'b100, 1'b1);
        @(negedge clk);
        en = 1'b1;
        wait_valid("50k", 3);
        en = 1'b0;

        // 1.25 MHz, matches no code
        period = 40;
        repeat (10) @(posedge clk);
        push(125, 1'b0, 3'b111, 1'b0);
        @(negedge clk);
        en = 1'b1;
        wait_valid("1m25", 4);
        en = 1'b0;

        // constant input
        period = 0;
        repeat (10) @(posedge clk);
        push(0, 1'b0, 3'b111, 1'b0);
        @(negedge clk);
        en = 1'b1;
        wait_valid("zero", 5);
        en = 1'b0;

        // abort mid-gate, then a fresh full gate
        period = 10;
        repeat (10) @(posedge clk);
        @(negedge clk);
        en = 1'b1;
        repeat (2000) @(posedge clk);
        @(negedge clk);
        en = 1'b0;
        repeat (GATE + 200) @(posedge clk);
        #2;
        chk("abort_no_valid", 32'(valid_seen), 32'd5);
        chk("abort_hold_cnt", 32'(cnt_out), 32'd0);
        chk("abort_hold_sel", 32'(sel_out), 32'd7);
        push(500, 1'b0, 3'b000, 1'b1);
        @(negedge clk);
        en = 1'b1;
        wait_valid("fresh", 6);
        en = 1'b0;

        // reset in the middle of a gate
        @(negedge clk);
        en = 1'b1;
        repeat (1000) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_cnt_out", 32'(cnt_out), 32'd0);
        chk("midrst_ovf", 32'(ovf), 32'd0);
        chk("midrst_valid", 32'(valid), 32'd0);
        chk("midrst_sel_out", 32'(sel_out), 32'd7);
        chk("midrst_sel_hit", 32'(sel_hit), 32'd0);
        en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (GATE + 200) @(posedge clk);
        #2;
        chk("midrst_no_stale_valid", 32'(valid_seen), 32'd6);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
